// File: rtl/vga_fb_pkg.sv
// Shared constants and FSM state type for the VGA framebuffer arbiter.
// The CLEAR state exists only when VGA_FB_ARBITER_CLEAR_EN is defined.
package vga_fb_pkg;

  localparam int FB_W      = 152;
  localparam int FB_H      = 120;
  localparam int ADDR_BITS = 15;
  localparam int DATA_BITS = 4;
  localparam int PIPE_LAT  = 3;

`ifdef VGA_FB_ARBITER_CLEAR_EN
  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_e;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_e;
`endif

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Pixel-writer request channel: valid/ready handshake plus a dropped-address error pulse.
interface vga_fb_arbiter_if #(
  parameter int ADDR_BITS = 15,
  parameter int DATA_BITS = 4
);

  logic                 valid;
  logic                 ready;
  logic                 err;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] data;

  modport master (output valid, addr, data, input ready, err);
  modport slave  (input valid, addr, data, output ready, err);

endinterface

// File: rtl/vga_fb_delay.sv
// N-stage shift register; every stage is flushed to RST_VAL by the synchronous reset.
module vga_fb_delay #(
  parameter int               N       = 3,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [N];

  // NOTE: every stage is reset, not just the output, so no stale sample survives reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-slot arbiter sharing one BRAM between VGA scan-out and a pixel writer.
// Optional clear sweep enabled by defining VGA_FB_ARBITER_CLEAR_EN.
module vga_fb_arbiter #(
  parameter int H_BITS    = 10,
  parameter int V_BITS    = 10,
  parameter int FB_W      = vga_fb_pkg::FB_W,
  parameter int FB_H      = vga_fb_pkg::FB_H,
  parameter int ADDR_BITS = vga_fb_pkg::ADDR_BITS,
`ifdef VGA_FB_ARBITER_CLEAR_EN
  parameter int CLEAR_COLOR = 0,
`endif
  parameter int DATA_BITS = vga_fb_pkg::DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [H_BITS-1:0]    h_counter,
  input  logic [V_BITS-1:0]    v_counter,
  input  logic                 visible_range,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  vga_fb_arbiter_if.slave      wr,
  output logic [ADDR_BITS-1:0] bram_addr,
  output logic [DATA_BITS-1:0] bram_wdata,
  output logic                 bram_we,
  input  logic [DATA_BITS-1:0] bram_rdata,
  output logic [DATA_BITS-1:0] pixel,
  output logic                 hsync,
  output logic                 vsync,
`ifdef VGA_FB_ARBITER_CLEAR_EN
  input  logic                 clear_req,
  output logic                 clear_busy,
`endif
  output logic                 frame_start
);

  import vga_fb_pkg::*;

  localparam int                   FB_SIZE   = FB_W * FB_H;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(FB_SIZE - 1);

  state_e               state;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [DATA_BITS-1:0] lat_data;

  logic [H_BITS-1:0]    col;
  logic [V_BITS-1:0]    row;
  logic                 in_range;
  logic                 scan;
  logic [ADDR_BITS-1:0] scan_addr;
  logic                 addr_bad;
  logic                 pend_done;

  assign col       = h_counter >> 1;
  assign row       = v_counter >> 2;
  assign in_range  = visible_range && (col < H_BITS'(FB_W)) && (row < V_BITS'(FB_H));
  assign scan      = in_range && !h_counter[0];
  assign scan_addr = ADDR_BITS'(row) * ADDR_BITS'(FB_W) + ADDR_BITS'(col);
  assign addr_bad  = lat_addr > LAST_ADDR;
  // A bad address finishes PENDING immediately; a good one waits for a writer slot.
  assign pend_done = (state == PENDING) && (addr_bad || !scan);

  assign frame_start = !RST && (h_counter == '0) && (v_counter == '0);

`ifdef VGA_FB_ARBITER_CLEAR_EN
  logic [ADDR_BITS-1:0] clr_addr;
  logic                 clr_queued;
`endif

  // NOTE: all registers here use <= so every branch sees pre-edge values of state and latches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wr.ready   <= 1'b0;
      wr.err     <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
`ifdef VGA_FB_ARBITER_CLEAR_EN
      clear_busy <= 1'b0;
      clr_addr   <= '0;
      clr_queued <= 1'b0;
`endif
    end else begin
      bram_we <= 1'b0;
      wr.err  <= 1'b0;
      if (scan) bram_addr <= scan_addr;

      case (state)
        IDLE: begin
          if (wr.valid && wr.ready) begin
            lat_addr <= wr.addr;
            lat_data <= wr.data;
            wr.ready <= 1'b0;
            state    <= PENDING;
`ifdef VGA_FB_ARBITER_CLEAR_EN
            clr_queued <= clear_req;
          end else if (clear_req) begin
            state      <= CLEAR;
            clear_busy <= 1'b1;
            clr_addr   <= '0;
            wr.ready   <= 1'b0;
`endif
          end else begin
            wr.ready <= 1'b1;
          end
        end

        PENDING: begin
          if (pend_done) begin
            if (addr_bad) begin
              wr.err <= 1'b1;
            end else begin
              bram_we    <= 1'b1;
              bram_addr  <= lat_addr;
              bram_wdata <= lat_data;
            end
`ifdef VGA_FB_ARBITER_CLEAR_EN
            if (clr_queued) begin
              state      <= CLEAR;
              clear_busy <= 1'b1;
              clr_addr   <= '0;
              clr_queued <= 1'b0;
            end else begin
              state    <= IDLE;
              wr.ready <= 1'b1;
            end
`else
            state    <= IDLE;
            wr.ready <= 1'b1;
`endif
          end
        end

`ifdef VGA_FB_ARBITER_CLEAR_EN
        CLEAR: begin
          if (!scan) begin
            bram_we    <= 1'b1;
            bram_addr  <= clr_addr;
            bram_wdata <= DATA_BITS'(CLEAR_COLOR);
            if (clr_addr == LAST_ADDR) begin
              state      <= IDLE;
              clear_busy <= 1'b0;
              wr.ready   <= 1'b1;
            end else begin
              clr_addr <= clr_addr + ADDR_BITS'(1);
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

  // Scan qualifiers are delayed two stages so the pixel register loads when bram_rdata is valid.
  logic [1:0] sync_q;
  logic [1:0] qual_q;

  vga_fb_delay #(.N(PIPE_LAT), .WIDTH(2), .RST_VAL(2'b11)) u_sync_dly (
    .CLK (CLK),
    .RST (RST),
    .d   ({hsync_in, vsync_in}),
    .q   (sync_q)
  );

  vga_fb_delay #(.N(PIPE_LAT - 1), .WIDTH(2), .RST_VAL(2'b00)) u_qual_dly (
    .CLK (CLK),
    .RST (RST),
    .d   ({in_range, scan}),
    .q   (qual_q)
  );

  assign hsync = sync_q[1];
  assign vsync = sync_q[0];

  // Odd columns hold the previous pixel, giving horizontal doubling.
  always_ff @(posedge CLK) begin
    if (RST)            pixel <= '0;
    else if (!qual_q[1]) pixel <= '0;
    else if (qual_q[0])  pixel <= bram_rdata;
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter; define VGA_FB_ARBITER_CLEAR_EN to also exercise the clear sweep.
module tb_vga_fb_arbiter;

  localparam int AB = 15;
  localparam int DB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [9:0]    h_counter = 10'd1;
  logic [9:0]    v_counter = 10'd1;
  logic          visible_range = 1'b0;
  logic          hsync_in = 1'b0;
  logic          vsync_in = 1'b0;
  logic [AB-1:0] bram_addr;
  logic [DB-1:0] bram_wdata;
  logic          bram_we;
  logic [DB-1:0] bram_rdata = '0;
  logic [DB-1:0] pixel;
  logic          hsync, vsync, frame_start;
`ifdef VGA_FB_ARBITER_CLEAR_EN
  logic          clear_req = 1'b0;
  logic          clear_busy;
`endif

  logic [DB-1:0] mem [1 << AB];

  always #5 CLK = ~CLK;

  vga_fb_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) wr_bus ();

  vga_fb_arbiter #(
    .H_BITS(10), .V_BITS(10), .FB_W(152), .FB_H(120), .ADDR_BITS(AB),
`ifdef VGA_FB_ARBITER_CLEAR_EN
    .CLEAR_COLOR(3),
`endif
    .DATA_BITS(DB)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .h_counter     (h_counter),
    .v_counter     (v_counter),
    .visible_range (visible_range),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .wr            (wr_bus),
    .bram_addr     (bram_addr),
    .bram_wdata    (bram_wdata),
    .bram_we       (bram_we),
    .bram_rdata    (bram_rdata),
    .pixel         (pixel),
    .hsync         (hsync),
    .vsync         (vsync),
`ifdef VGA_FB_ARBITER_CLEAR_EN
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
`endif
    .frame_start   (frame_start)
  );

  // Read-first single-port BRAM model.
  always @(posedge CLK) begin
    if (bram_we) mem[bram_addr] <= bram_wdata;
    bram_rdata <= mem[bram_addr];
  end

  typedef struct {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } wr_t;

  wr_t wq[$];
  int  eq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic model_scan(logic [9:0] h, logic [9:0] v, logic vis);
    return vis && !h[0] && ((h >> 1) < 152) && ((v >> 2) < 120);
  endfunction

  // Monitor: pops expected writes/errors whenever the DUT presents one.
  logic last_scan = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      last_scan = 1'b0;
    end else begin
      if (bram_we) begin
        check("we_not_after_scan", last_scan, 1'b0);
        check("write_expected", wq.size() > 0, 1'b1);
        if (wq.size() > 0) begin
          wr_t e;
          e = wq.pop_front();
          check("we_addr", bram_addr, e.addr);
          check("we_data", bram_wdata, e.data);
        end
      end
      if (wr_bus.err) begin
        check("err_expected", eq.size() > 0, 1'b1);
        if (eq.size() > 0) void'(eq.pop_front());
        check("err_no_we", bram_we, 1'b0);
      end
      last_scan = model_scan(h_counter, v_counter, visible_range);
    end
  end

  logic [7:0] hpat = 8'b1011_0010;
  int         h_tab   [12] = '{2, 3, 4, 5, 304, 6, 7, 8, 9, 10, 11, 12};
  logic       vis_tab [12] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
  logic [3:0] pix_tab [12] = '{0, 0, 0, 4'hA, 4'hA, 4'h6, 4'h6, 0, 0, 0, 0, 0};

  initial begin
    logic e_h, e_v;
    wr_bus.valid = 1'b0;
    wr_bus.addr  = '0;
    wr_bus.data  = '0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
    mem[153] = 4'hA;
    mem[154] = 4'h6;

    // Reset values
    repeat (3) cyc();
    @(negedge CLK);
    check("rst_wr_ready", wr_bus.ready, 1'b0);
    check("rst_wr_err", wr_bus.err, 1'b0);
    check("rst_bram_we", bram_we, 1'b0);
    check("rst_bram_addr", bram_addr, 0);
    check("rst_bram_wdata", bram_wdata, 0);
    check("rst_pixel", pixel, 0);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_frame_start", frame_start, 1'b0);

    // Release: syncs stay high 3 cycles then follow inputs delayed by 3
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (k == 0) RST = 1'b0;
      hsync_in = hpat[k];
      vsync_in = !hpat[k];
      @(negedge CLK);
      e_h = (k < 3) ? 1'b1 : hpat[k-3];
      e_v = (k < 3) ? 1'b1 : !hpat[k-3];
      check("hsync_delay", hsync, e_h);
      check("vsync_delay", vsync, e_v);
      if (k == 0) check("ready_release_c0", wr_bus.ready, 1'b0);
      if (k == 1) check("ready_release_c1", wr_bus.ready, 1'b1);
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;

    cyc(); h_counter = 10'd0; v_counter = 10'd0;
    @(negedge CLK); check("frame_start_hi", frame_start, 1'b1);
    cyc(); h_counter = 10'd1;
    @(negedge CLK); check("frame_start_lo", frame_start, 1'b0);

    // Scan-out pipeline: addr at t+1, pixel at t+3, doubled on odd h
    for (int i = 0; i < 12; i++) begin
      cyc();
      h_counter     = 10'(h_tab[i]);
      v_counter     = 10'd4;
      visible_range = vis_tab[i];
      @(negedge CLK);
      check("pixel", pixel, pix_tab[i]);
      if (i == 1) check("scan_addr_153", bram_addr, 153);
      if (i == 3) check("scan_addr_154", bram_addr, 154);
    end

    // Best case: accepted in a scan slot, committed in the next writer slot
    cyc(); h_counter = 10'd4; visible_range = 1'b1;
    wr_bus.valid = 1'b1; wr_bus.addr = 15'd10; wr_bus.data = 4'h5;
    wq.push_back('{addr: 15'd10, data: 4'h5});
    @(negedge CLK); check("best_ready_t", wr_bus.ready, 1'b1);
    cyc(); h_counter = 10'd5; wr_bus.valid = 1'b0;
    @(negedge CLK); check("best_ready_t1", wr_bus.ready, 1'b0); check("best_we_t1", bram_we, 1'b0);
    cyc(); h_counter = 10'd7;
    @(negedge CLK); check("best_we_t2", bram_we, 1'b1); check("best_ready_t2", wr_bus.ready, 1'b1);

    // Worst case: accepted at odd h, next cycle is a scan slot
    cyc(); h_counter = 10'd3;
    wr_bus.valid = 1'b1; wr_bus.addr = 15'd20; wr_bus.data = 4'hC;
    wq.push_back('{addr: 15'd20, data: 4'hC});
    cyc(); h_counter = 10'd4; wr_bus.valid = 1'b0;
    cyc(); h_counter = 10'd5;
    @(negedge CLK); check("worst_we_t2", bram_we, 1'b0); check("worst_scan_addr", bram_addr, 154);
    cyc(); h_counter = 10'd7;
    @(negedge CLK); check("worst_we_t3", bram_we, 1'b1); check("worst_ready_t3", wr_bus.ready, 1'b1);

    // Out-of-range address dropped with error; last valid address accepted
    cyc(); visible_range = 1'b0; h_counter = 10'd1;
    wr_bus.valid = 1'b1; wr_bus.addr = 15'd18240; wr_bus.data = 4'h1;
    eq.push_back(18240);
    cyc(); wr_bus.valid = 1'b0;
    cyc();
    @(negedge CLK); check("err_pulse", wr_bus.err, 1'b1); check("err_ready", wr_bus.ready, 1'b1);
    wr_bus.valid = 1'b1; wr_bus.addr = 15'd18239; wr_bus.data = 4'h7;
    wq.push_back('{addr: 15'd18239, data: 4'h7});
    cyc(); wr_bus.valid = 1'b0;
    @(negedge CLK); check("err_pulse_end", wr_bus.err, 1'b0);
    repeat (3) cyc();

    // Reset while PENDING discards the request
    wr_bus.valid = 1'b1; wr_bus.addr = 15'd30; wr_bus.data = 4'h2;
    cyc(); wr_bus.valid = 1'b0; RST = 1'b1;
    cyc(); RST = 1'b0;
    @(negedge CLK);
    check("rstp_bram_we", bram_we, 1'b0);
    check("rstp_ready", wr_bus.ready, 1'b0);
    check("rstp_err", wr_bus.err, 1'b0);
    check("rstp_addr", bram_addr, 0);
    check("rstp_wdata", bram_wdata, 0);
    check("rstp_pixel", pixel, 0);
    check("rstp_hsync", hsync, 1'b1);
    check("rstp_vsync", vsync, 1'b1);
    cyc();
    @(negedge CLK); check("rstp_ready_back", wr_bus.ready, 1'b1);
    repeat (5) cyc();

`ifdef VGA_FB_ARBITER_CLEAR_EN
    // Write together with clear_req: write first, then sweep of color 3
    begin
      int hh;
      visible_range = 1'b1; v_counter = 10'd0; h_counter = 10'd1;
      wr_bus.valid = 1'b1; wr_bus.addr = 15'd5; wr_bus.data = 4'h9; clear_req = 1'b1;
      wq.push_back('{addr: 15'd5, data: 4'h9});
      for (int a = 0; a < 18240; a++) wq.push_back('{addr: AB'(a), data: 4'h3});
      cyc(); wr_bus.valid = 1'b0; clear_req = 1'b0; h_counter = 10'd2;
      hh = 2;
      for (int c = 0; c < 50000 && wq.size() != 0; c++) begin
        cyc();
        hh = (hh + 1) % 304;
        h_counter = 10'(hh);
        clear_req = (c == 100);
        @(negedge CLK);
        if (c == 1) check("clear_busy_hi", clear_busy, 1'b1);
        if (c == 1) check("clear_ready_lo", wr_bus.ready, 1'b0);
      end
      clear_req = 1'b0;
      check("clear_drained", wq.size(), 0);
      cyc();
      @(negedge CLK);
      check("clear_busy_lo", clear_busy, 1'b0);
      check("clear_ready_back", wr_bus.ready, 1'b1);
      visible_range = 1'b0;
      repeat (5) cyc();
    end
`endif

    for (int c = 0; c < 10 && (wq.size() != 0 || eq.size() != 0); c++) cyc();
    check("write_queue_empty", wq.size(), 0);
    check("err_queue_empty", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
